// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Turns decoded LEGv8 instruction descriptions into 32-bit machine words
// that can be written into instruction memory. Each descriptor is accepted
// with a valid/ready handshake. Its immediate is range-checked for the
// target format, and the encoded word leaves through a single registered
// output stage. The stage also carries the word's byte address.
//
// Supported ops (in_op): 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 LSL,
// 7 LSR, 8 B, 9 CBZ, 10 CBNZ, 11 ADDI, 12 SUBI, 13 ANDI, 14 ORRI; 15 illegal.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high (highest priority)
//   clear      in   synchronous restart of address counter, output and error
//   in_valid   in   descriptor present
//   in_ready   out  descriptor accepted when in_valid && in_ready
//   in_op      in   [3:0] operation select
//   in_rd      in   [4:0] Rd / Rt field
//   in_rn      in   [4:0] Rn field
//   in_rm      in   [4:0] Rm field
//   in_imm     in   [31:0] two's-complement shamt / offset / displacement
//   out_valid  out  encoded word held in the output stage
//   out_ready  in   downstream consumes when out_valid && out_ready
//   out_instr  out  [31:0] encoded word
//   out_addr   out  [ADDR_W-1:0] byte address of out_instr
//   count      out  words accepted since reset/clear (never wraps)
//   full       out  count == DEPTH
//   err        out  sticky error flag
//   err_code   out  [1:0] first error: 00 none, 01 illegal op, 10 imm range
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
    parameter int unsigned         DEPTH     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,

    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_op,
    input  logic [4:0]                   in_rd,
    input  logic [4:0]                   in_rn,
    input  logic [4:0]                   in_rm,
    input  logic [31:0]                  in_imm,

    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [ADDR_W-1:0]            out_addr,

    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         err,
    output logic [1:0]                   err_code
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_AND     = 4'd2,
        OP_ORR     = 4'd3,
        OP_LDUR    = 4'd4,
        OP_STUR    = 4'd5,
        OP_LSL     = 4'd6,
        OP_LSR     = 4'd7,
        OP_B       = 4'd8,
        OP_CBZ     = 4'd9,
        OP_CBNZ    = 4'd10,
        OP_ADDI    = 4'd11,
        OP_SUBI    = 4'd12,
        OP_ANDI    = 4'd13,
        OP_ORRI    = 4'd14,
        OP_ILLEGAL = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_RANGE   = 2'b10
    } err_e;

    // Opcode fields, grouped by format width.
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LSL  = 11'b11010011011;
    localparam logic [10:0] OPC_LSR  = 11'b11010011010;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [9:0]  OPC_ANDI = 10'b1001001000;
    localparam logic [9:0]  OPC_ORRI = 10'b1011001000;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_addr_q,  out_addr_d;
    logic [CW-1:0]      count_q,     count_d;
    logic               err_q,       err_d;
    err_e               err_code_q,  err_code_d;

    // ------------------------------------------------------------------------
    // Combinational decode: encoded word, op legality, immediate range
    // ------------------------------------------------------------------------
    op_e         op;
    logic [31:0] enc_word;
    logic        op_legal;
    logic        imm_ok;

    assign op = op_e'(in_op);

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        enc_word = '0;
        op_legal = 1'b1;
        imm_ok   = 1'b1;

        unique case (op)
            OP_ADD:  enc_word = {OPC_ADD, in_rm, 6'b0, in_rn, in_rd};
            OP_SUB:  enc_word = {OPC_SUB, in_rm, 6'b0, in_rn, in_rd};
            OP_AND:  enc_word = {OPC_AND, in_rm, 6'b0, in_rn, in_rd};
            OP_ORR:  enc_word = {OPC_ORR, in_rm, 6'b0, in_rn, in_rd};

            // Shifts: Rm slot is forced to zero; shamt is unsigned 0..63.
            OP_LSL: begin
                enc_word = {OPC_LSL, 5'b0, in_imm[5:0], in_rn, in_rd};
                imm_ok   = (in_imm[31:6] == '0);
            end
            OP_LSR: begin
                enc_word = {OPC_LSR, 5'b0, in_imm[5:0], in_rn, in_rd};
                imm_ok   = (in_imm[31:6] == '0);
            end

            // D-format: 9-bit signed offset. It fits when bits above the
            // sign bit are all copies of it.
            OP_LDUR: begin
                enc_word = {OPC_LDUR, in_imm[8:0], 2'b00, in_rn, in_rd};
                imm_ok   = (in_imm[31:9] == {23{in_imm[8]}});
            end
            OP_STUR: begin
                enc_word = {OPC_STUR, in_imm[8:0], 2'b00, in_rn, in_rd};
                imm_ok   = (in_imm[31:9] == {23{in_imm[8]}});
            end

            // I-format: 12-bit unsigned immediate.
            OP_ADDI: begin
                enc_word = {OPC_ADDI, in_imm[11:0], in_rn, in_rd};
                imm_ok   = (in_imm[31:12] == '0);
            end
            OP_SUBI: begin
                enc_word = {OPC_SUBI, in_imm[11:0], in_rn, in_rd};
                imm_ok   = (in_imm[31:12] == '0);
            end
            OP_ANDI: begin
                enc_word = {OPC_ANDI, in_imm[11:0], in_rn, in_rd};
                imm_ok   = (in_imm[31:12] == '0);
            end
            OP_ORRI: begin
                enc_word = {OPC_ORRI, in_imm[11:0], in_rn, in_rd};
                imm_ok   = (in_imm[31:12] == '0);
            end

            // B-format: 26-bit signed word displacement.
            OP_B: begin
                enc_word = {OPC_B, in_imm[25:0]};
                imm_ok   = (in_imm[31:26] == {6{in_imm[25]}});
            end

            // CB-format: 19-bit signed word displacement, Rt in [4:0].
            OP_CBZ: begin
                enc_word = {OPC_CBZ, in_imm[18:0], in_rd};
                imm_ok   = (in_imm[31:19] == {13{in_imm[18]}});
            end
            OP_CBNZ: begin
                enc_word = {OPC_CBNZ, in_imm[18:0], in_rd};
                imm_ok   = (in_imm[31:19] == {13{in_imm[18]}});
            end

            default: op_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic accept;
    logic good_word;
    logic consumed;

    assign full = (count_q == CW'(DEPTH));

    // The downstream ready feeds straight through to in_ready. A held word
    // that leaves this cycle frees the stage for a new one, so continuous
    // flow has no bubbles.
    assign in_ready  = !rst && !clear && !full && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign good_word = accept && op_legal && imm_ok;
    assign consumed  = out_valid_q && out_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        count_d     = count_q;
        err_d       = err_q;
        err_code_d  = err_code_q;

        if (clear) begin
            // Restart: a pending word is dropped, not delivered.
            out_valid_d = 1'b0;
            out_instr_d = '0;
            out_addr_d  = BASE_ADDR;
            count_d     = '0;
            err_d       = 1'b0;
            err_code_d  = ERR_NONE;
        end else begin
            if (consumed) begin
                out_valid_d = 1'b0;
            end

            if (good_word) begin
                // The address uses the pre-increment count. A word that
                // loads on the same edge as a consume keeps out_valid high.
                out_valid_d = 1'b1;
                out_instr_d = enc_word;
                out_addr_d  = BASE_ADDR + (ADDR_W'(count_q) << 2);
                count_d     = count_q + CW'(1);
            end else if (accept) begin
                // A rejected descriptor still completes its handshake.
                // Only the first error cause is kept.
                err_d = 1'b1;
                if (err_code_q == ERR_NONE) begin
                    err_code_d = op_legal ? ERR_RANGE : ERR_ILLEGAL;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            count_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign count     = count_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed scenarios plus a randomized run of instr_encoder. All of them are
// checked against a transaction-level reference model. The model builds each
// word with integer arithmetic from the format tables. It checks immediates
// with signed integer ranges. It tracks the output stage as
// valid/word/address/count/error variables.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_addr;
    logic [CW-1:0]     count;
    logic              full;
    logic              err;
    logic [1:0]        err_code;

    instr_encoder #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0),
        .DEPTH     (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rn     (in_rn),
        .in_rm     (in_rm),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .count     (count),
        .full      (full),
        .err       (err),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_addr;
    int          m_count;
    bit          m_err;
    logic [1:0]  m_code;
    bit          exp_ready;
    logic        seen_ready;

    logic [31:0] edge_vals [18] = '{
        32'h0000_0000, 32'h0000_003F, 32'h0000_0040, 32'h0000_00FF,
        32'h0000_0100, 32'hFFFF_FF00, 32'hFFFF_FEFF, 32'h0000_0FFF,
        32'h0000_1000, 32'h0003_FFFF, 32'h0004_0000, 32'hFFFC_0000,
        32'hFFFB_FFFF, 32'h01FF_FFFF, 32'h0200_0000, 32'hFE00_0000,
        32'hFDFF_FFFF, 32'hFFFF_FFFF
    };

    function automatic longint pow2(input int n);
        return longint'(1) << n;
    endfunction

    // Low n bits of a signed value, as a non-negative integer.
    function automatic longint field(input longint v, input int n);
        return ((v % pow2(n)) + pow2(n)) % pow2(n);
    endfunction

    function automatic void model_encode(
        input  logic [3:0]  op,
        input  logic [4:0]  rd,
        input  logic [4:0]  rn,
        input  logic [4:0]  rm,
        input  logic [31:0] imm,
        output bit          ok,
        output logic [1:0]  code,
        output logic [31:0] word
    );
        longint s = longint'($signed(imm));
        longint w = 0;
        longint r_opc;
        longint lo;
        longint hi;
        ok   = 1'b1;
        code = 2'b00;
        lo   = 0;
        hi   = 0;
        case (op)
            0, 1, 2, 3: begin
                r_opc = (op == 0) ? 'h458 : (op == 1) ? 'h658 : (op == 2) ? 'h450 : 'h550;
                w = r_opc * pow2(21) + longint'(rm) * pow2(16) + longint'(rn) * 32 + longint'(rd);
            end
            4, 5: begin
                lo = -256; hi = 255;
                w = ((op == 4) ? 'h7C2 : 'h7C0) * pow2(21) + field(s, 9) * pow2(12)
                    + longint'(rn) * 32 + longint'(rd);
            end
            6, 7: begin
                lo = 0; hi = 63;
                w = ((op == 6) ? 'h69B : 'h69A) * pow2(21) + field(s, 6) * pow2(10)
                    + longint'(rn) * 32 + longint'(rd);
            end
            8: begin
                lo = -pow2(25); hi = pow2(25) - 1;
                w = 5 * pow2(26) + field(s, 26);
            end
            9, 10: begin
                lo = -pow2(18); hi = pow2(18) - 1;
                w = ((op == 9) ? 'hB4 : 'hB5) * pow2(24) + field(s, 19) * 32 + longint'(rd);
            end
            11, 12, 13, 14: begin
                lo = 0; hi = 4095;
                r_opc = (op == 11) ? 'h244 : (op == 12) ? 'h344 : (op == 13) ? 'h248 : 'h2C8;
                w = r_opc * pow2(22) + field(s, 12) * pow2(10) + longint'(rn) * 32 + longint'(rd);
            end
            default: begin
                ok   = 1'b0;
                code = 2'b01;
            end
        endcase
        if (ok && op > 3 && (s < lo || s > hi)) begin
            ok   = 1'b0;
            code = 2'b10;
        end
        word = w[31:0];
    endfunction

    // Advance one clock. in_ready is sampled mid-cycle. The model is stepped
    // with the inputs as they stood at the edge. Return is #1 after the edge.
    task automatic tick();
        bit          consumed;
        bit          ok;
        logic [1:0]  code;
        logic [31:0] word;
        @(negedge clk);
        seen_ready = in_ready;
        exp_ready  = !rst && !clear && (m_count != DEPTH) && (!m_valid || out_ready);
        consumed   = m_valid && out_ready;
        if (rst || clear) begin
            m_valid = 0; m_instr = '0; m_addr = '0; m_count = 0; m_err = 0; m_code = 2'b00;
        end else if (in_valid && exp_ready) begin
            model_encode(in_op, in_rd, in_rn, in_rm, in_imm, ok, code, word);
            if (ok) begin
                m_valid = 1; m_instr = word; m_addr = 32'(4 * m_count); m_count++;
            end else begin
                m_err = 1;
                if (m_code == 2'b00) m_code = code;
                if (consumed) m_valid = 0;
            end
        end else if (consumed) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [31:0] imm);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
    endtask

    task automatic do_clear();
        in_valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        int k = $urandom_range(0, 3);
        case (k)
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 4200));
            2:       return edge_vals[$urandom_range(0, 17)];
            default: return 32'($urandom_range(0, 600)) - 32'd300;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        drive(0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", seen_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr got=%h want=0", out_instr); end
        total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL reset_out_addr got=%h want=0", out_addr); end
        total++; if (count !== '0 || full !== 1'b0) begin bad++; $display("FAIL reset_count got=%0d/%b want=0/0", count, full); end
        total++; if (err !== 1'b0 || err_code !== 2'b00) begin bad++; $display("FAIL reset_err got=%b/%b want=0/00", err, err_code); end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got=%b want=1", seen_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_out_valid got=%b want=1", out_valid); end
        total++; if (out_instr !== 32'h8B020023) begin bad++; $display("FAIL add_instr got=%h want=8b020023", out_instr); end
        total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL add_addr got=%h want=0", out_addr); end
        total++; if (count !== CW'(1)) begin bad++; $display("FAIL add_count got=%0d want=1", count); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_clear();
        out_ready = 1'b1;
        drive(11, 5'd9, 5'd9, 5'd17, 32'd1);
        tick();
        total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0 got=%b want=1", seen_ready); end
        total++; if (out_instr !== 32'h91000529 || out_addr !== 32'h0) begin bad++; $display("FAIL b2b_word0 got=%h@%h want=91000529@0", out_instr, out_addr); end
        drive(4, 5'd2, 5'd10, 5'd0, 32'd8);
        tick();
        total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b want=1", seen_ready); end
        total++; if (out_valid !== 1'b1 || out_instr !== 32'hF8408142 || out_addr !== 32'h4) begin bad++; $display("FAIL b2b_word1 got=%b %h@%h want=1 f8408142@4", out_valid, out_instr, out_addr); end
        total++; if (count !== CW'(2)) begin bad++; $display("FAIL b2b_count got=%0d want=2", count); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        do_clear();
        out_ready = 1'b1;
        drive(8, 5'($urandom), 5'($urandom), 5'($urandom), 32'hFFFF_FFFD);
        tick();
        total++; if (out_instr !== 32'h17FFFFFD || out_addr !== 32'h0) begin bad++; $display("FAIL stall_b got=%h@%h want=17fffffd@0", out_instr, out_addr); end
        drive(9, 5'd5, 5'($urandom), 5'($urandom), 32'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=0", i, seen_ready); end
            total++; if (out_valid !== 1'b1 || out_instr !== 32'h17FFFFFD || out_addr !== 32'h0) begin bad++; $display("FAIL stall_hold[%0d] got=%b %h@%h want=1 17fffffd@0", i, out_valid, out_instr, out_addr); end
        end
        out_ready = 1'b1;
        tick();
        total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b want=1", seen_ready); end
        total++; if (out_valid !== 1'b1 || out_instr !== 32'hB4000085 || out_addr !== 32'h4) begin bad++; $display("FAIL stall_cbz got=%b %h@%h want=1 b4000085@4", out_valid, out_instr, out_addr); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_errors();
        do_clear();
        out_ready = 1'b1;
        drive(11, 5'd1, 5'd2, 5'd3, 32'd4096);
        tick();
        total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL err_range_ready got=%b want=1", seen_ready); end
        total++; if (out_valid !== 1'b0 || count !== '0) begin bad++; $display("FAIL err_range_noword got=%b/%0d want=0/0", out_valid, count); end
        total++; if (err !== 1'b1 || err_code !== 2'b10) begin bad++; $display("FAIL err_range_code got=%b/%b want=1/10", err, err_code); end
        drive(15, 5'd1, 5'd1, 5'd1, 32'd0);
        tick();
        total++; if (err !== 1'b1 || err_code !== 2'b10 || count !== '0) begin bad++; $display("FAIL err_first_kept got=%b/%b/%0d want=1/10/0", err, err_code, count); end
        drive(6, 5'd1, 5'd1, 5'd9, 32'd4);
        tick();
        total++; if (out_valid !== 1'b1 || out_instr !== 32'hD3601021 || out_addr !== 32'h0) begin bad++; $display("FAIL err_lsl got=%b %h@%h want=1 d3601021@0", out_valid, out_instr, out_addr); end
        total++; if (err !== 1'b1 || count !== CW'(1)) begin bad++; $display("FAIL err_sticky got=%b/%0d want=1/1", err, count); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_full();
        do_clear();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 5'(i), 5'd1, 5'd2, 32'd0);
            tick();
            total++; if (seen_ready !== 1'b1 || out_addr !== 32'(4 * i)) begin bad++; $display("FAIL full_fill[%0d] got=%b @%h want=1 @%h", i, seen_ready, out_addr, 32'(4 * i)); end
        end
        total++; if (count !== CW'(DEPTH) || full !== 1'b1) begin bad++; $display("FAIL full_flag got=%0d/%b want=%0d/1", count, full, DEPTH); end
        tick();
        total++; if (seen_ready !== 1'b0 || count !== CW'(DEPTH) || out_valid !== 1'b0) begin bad++; $display("FAIL full_block got=%b/%0d/%b want=0/%0d/0", seen_ready, count, out_valid, DEPTH); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL clear_ready got=%b want=0", seen_ready); end
        total++; if (count !== '0 || full !== 1'b0 || err !== 1'b0 || out_valid !== 1'b0 || out_addr !== 32'h0) begin bad++; $display("FAIL clear_state got=%0d/%b/%b/%b/%h want=0/0/0/0/0", count, full, err, out_valid, out_addr); end
        drive(1, 5'd4, 5'd5, 5'd6, 32'd0);
        tick();
        total++; if (out_valid !== 1'b1 || out_addr !== 32'h0 || out_instr !== 32'hCB0600A4) begin bad++; $display("FAIL clear_next got=%b %h@%h want=1 cb0600a4@0", out_valid, out_instr, out_addr); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_rst_midflow();
        do_clear();
        out_ready = 1'b0;
        drive(2, 5'd7, 5'd8, 5'd9, 32'd0);
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_setup got=%b want=1", out_valid); end
        rst = 1'b1;
        tick();
        total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b want=0", seen_ready); end
        total++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 32'h0 || count !== '0) begin bad++; $display("FAIL rstmid_state got=%b %h@%h %0d want=0 0@0 0", out_valid, out_instr, out_addr, count); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        total++; if (count !== '0 || out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_noaccept got=%0d/%b want=0/0", count, out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            in_op     = 4'($urandom_range(0, 15));
            in_rd     = 5'($urandom);
            in_rn     = 5'($urandom);
            in_rm     = 5'($urandom);
            in_imm    = rand_imm();
            tick();
            total++; if (seen_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", i, seen_ready, exp_ready); end
            total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, out_valid, m_valid); end
            if (m_valid) begin
                total++; if (out_instr !== m_instr || out_addr !== m_addr) begin bad++; $display("FAIL rnd_word[%0d] got=%h@%h want=%h@%h", i, out_instr, out_addr, m_instr, m_addr); end
            end
            total++; if (count !== CW'(m_count) || full !== (m_count == DEPTH)) begin bad++; $display("FAIL rnd_count[%0d] got=%0d/%b want=%0d", i, count, full, m_count); end
            total++; if (err !== m_err || err_code !== m_code) begin bad++; $display("FAIL rnd_err[%0d] got=%b/%b want=%b/%b", i, err, err_code, m_err, m_code); end
        end
        clear = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0;
        m_valid = 0; m_instr = '0; m_addr = '0; m_count = 0; m_err = 0; m_code = 2'b00;
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_errors();
        test_full();
        test_rst_midflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
